// File: rtl/seq_div_pkg.sv
// Shared types and bit-cell functions for the sequential restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Row `row` sits (w-1-row) steps before the final row; the approximate
  // region tapers by one LSB cell per step.
  function automatic logic [31:0] approx_cells(input int unsigned row,
                                               input int unsigned w,
                                               input int unsigned approx_bits);
    int unsigned steps;
    int unsigned n;
    logic [31:0] m;
    m     = '0;
    steps = w - 1 - row;
    n     = (approx_bits > steps) ? approx_bits - steps : 0;
    for (int unsigned b = 0; b < 32; b++) m[b] = (b < n);
    return m;
  endfunction

  function automatic logic exact_borrow(input logic a, input logic y, input logic bin);
    return (~a & bin) | (~a & y) | (y & bin);
  endfunction

  function automatic logic exact_rem(input logic a, input logic y, input logic bin,
                                     input logic qs);
    return qs ? (a ^ y ^ bin) : a;
  endfunction

  function automatic logic approx_borrow(input logic a, input logic y, input logic bin);
    return bin & (y | ~a);
  endfunction

  function automatic logic approx_rem(input logic a, input logic y, input logic bin,
                                      input logic qs);
    return a | (qs & (y ^ bin));
  endfunction

endpackage

// File: rtl/div_row.sv
// One combinational subtract/restore row of the divider with per-bit approximate cells.
import seq_div_pkg::*;

module div_row #(
  parameter int W = 8
) (
  input  logic [W:0]   x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] amask,
  output logic         qs,
  output logic [W-1:0] r
);

  logic [W:0] b;

  // The borrow chain must settle before qs is known, and every remainder
  // bit depends on qs, so the row is evaluated in two passes.
  always_comb begin
    b  = '0;
    r  = '0;
    for (int unsigned k = 0; k < W; k++)
      b[k+1] = amask[k] ? approx_borrow(x[k], y[k], b[k])
                        : exact_borrow(x[k], y[k], b[k]);
    qs = ~b[W] | x[W];
    for (int unsigned k = 0; k < W; k++)
      r[k] = amask[k] ? approx_rem(x[k], y[k], b[k], qs)
                      : exact_rem(x[k], y[k], b[k], qs);
  end

endmodule

// File: rtl/seq_approx_divider.sv
// Iterative 2W/W restoring divider, one row per clock, with tapered approximate LSB cells.
import seq_div_pkg::*;

module seq_approx_divider #(
  parameter int W           = 8,
  parameter int APPROX_BITS = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  input  logic           approx_en,
  output logic           ready,
  output logic           done,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           ovf
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t        state, state_n;
  logic [W-1:0]  rreg, dreg, yreg, qacc;
  logic          areg;
  logic [CW-1:0] cnt;
  logic [W-1:0]  hi, amask, row_r;
  logic          row_qs, accept, ovf_now, last;

  assign hi      = dividend[2*W-1:W];
  assign ready   = (state != RUN);
  assign accept  = ready & start;
  assign ovf_now = (hi >= divisor);
  assign last    = (state == RUN) && (cnt == CW'(W - 1));
  assign amask   = areg ? W'(approx_cells(32'(cnt), W, APPROX_BITS)) : '0;

  div_row #(.W(W)) u_row (
    .x     ({rreg, dreg[W-1]}),
    .y     (yreg),
    .amask (amask),
    .qs    (row_qs),
    .r     (row_r)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (start)               state_n = ovf_now ? DONE : RUN;
        else if (state == DONE)  state_n = IDLE;
      end
      RUN:     if (last) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Dividend bits are shifted out MSB-first and quotient bits shifted in at
  // the LSB, so after W rows row i's qs lands on bit W-1-i.
  always_ff @(posedge clk) begin
    if (rst) begin
      rreg      <= '0;
      dreg      <= '0;
      yreg      <= '0;
      qacc      <= '0;
      areg      <= 1'b0;
      cnt       <= '0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        rreg <= hi;
        dreg <= dividend[W-1:0];
        yreg <= divisor;
        areg <= approx_en;
        cnt  <= '0;
        qacc <= '0;
        if (ovf_now) begin
          quotient  <= '1;
          remainder <= hi;
          ovf       <= 1'b1;
          done      <= 1'b1;
        end
      end else if (state == RUN) begin
        rreg <= row_r;
        dreg <= {dreg[W-2:0], 1'b0};
        qacc <= {qacc[W-2:0], row_qs};
        cnt  <= cnt + 1'b1;
        if (last) begin
          quotient  <= {qacc[W-2:0], row_qs};
          remainder <= row_r;
          ovf       <= 1'b0;
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_approx_divider.sv
// Directed-vector bench for seq_approx_divider with a cycle-level reference model.
module tb_seq_approx_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, approx_en;
  logic [15:0]  dividend;
  logic [7:0]   divisor;
  logic         ready, done, ovf;
  logic [7:0]   quotient, remainder;

  int n_pass = 0;
  int n_chk  = 0;

  // model state
  logic       armed = 1'b0;
  logic       m_ready, m_done, m_ovf;
  logic [7:0] m_q, m_r, pq, pr;
  int         m_cnt;
  logic [7:0] exp_aq, exp_ar;

  always #5 clk = ~clk;

  seq_approx_divider #(.W(W), .APPROX_BITS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .approx_en (approx_en),
    .ready     (ready),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: a division takes W cycles; approximate results come from hand values.
  always @(posedge clk) begin
    if (rst) begin
      armed = 1'b1; m_ready = 1'b1; m_done = 1'b0; m_ovf = 1'b0;
      m_q = '0; m_r = '0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1; m_ready = 1'b1; m_q = pq; m_r = pr; m_ovf = 1'b0;
        end
      end else if (start) begin
        if (dividend[15:8] >= divisor) begin
          m_q = 8'hFF; m_r = dividend[15:8]; m_ovf = 1'b1; m_done = 1'b1;
        end else begin
          m_cnt = W; m_ready = 1'b0;
          if (approx_en) begin
            pq = exp_aq; pr = exp_ar;
          end else begin
            pq = 8'(dividend / divisor);
            pr = 8'(dividend % divisor);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("ready", ready, m_ready);
      check("done", done, m_done);
      check("quotient", quotient, m_q);
      check("remainder", remainder, m_r);
      check("ovf", ovf, m_ovf);
    end
  end

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic go(input logic [15:0] dvd, input logic [7:0] dvs, input logic ap,
                    input logic [7:0] eq, input logic [7:0] er, input logic eo,
                    input int exp_lat);
    int lat;
    @(negedge clk);
    dividend = dvd; divisor = dvs; approx_en = ap;
    exp_aq = eq; exp_ar = er; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("latency", lat, exp_lat);
    check("q_lit", quotient, eq);
    check("r_lit", remainder, er);
    check("ovf_lit", ovf, eo);
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; approx_en = 1'b0; dividend = '0; divisor = '0;
    exp_aq = '0; exp_ar = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_q", quotient, 8'h00);
    rst = 1'b0;

    go(16'h03E8, 8'h64, 1'b0, 8'h0A, 8'h00, 1'b0, 8);
    go(16'h03E8, 8'h64, 1'b1, 8'h0A, 8'h00, 1'b0, 8);
    go(16'h0003, 8'h01, 1'b0, 8'h03, 8'h00, 1'b0, 8);
    go(16'h0003, 8'h01, 1'b1, 8'h03, 8'h03, 1'b0, 8);
    go(16'h7FFF, 8'h80, 1'b0, 8'hFF, 8'h7F, 1'b0, 8);
    go(16'h6400, 8'h64, 1'b0, 8'hFF, 8'h64, 1'b1, 0);
    go(16'h0100, 8'h00, 1'b0, 8'hFF, 8'h01, 1'b1, 0);

    // start during RUN is ignored
    @(negedge clk);
    dividend = 16'h03E8; divisor = 8'h64; approx_en = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    dividend = 16'h0050; divisor = 8'h07; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(lat);
    check("ign_latency", lat, 6);
    check("ign_q", quotient, 8'h0A);
    check("ign_r", remainder, 8'h00);

    // start held through DONE: back-to-back
    @(negedge clk);
    dividend = 16'h03E8; divisor = 8'h64; start = 1'b1;
    @(negedge clk);
    dividend = 16'h1234; divisor = 8'h56;
    wait_done(lat);
    check("b2b_lat_a", lat, 8);
    check("b2b_q_a", quotient, 8'h0A);
    @(negedge clk); start = 1'b0;
    check("b2b_busy", ready, 1'b0);
    wait_done(lat);
    check("b2b_lat_b", lat, 8);
    check("b2b_q_b", quotient, 8'h36);
    check("b2b_r_b", remainder, 8'h10);

    // reset in the middle of a run
    @(negedge clk);
    dividend = 16'h03E8; divisor = 8'h64; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("mid_rst_ready", ready, 1'b1);
    check("mid_rst_q", quotient, 8'h00);
    check("mid_rst_r", remainder, 8'h00);
    check("mid_rst_done", done, 1'b0);
    repeat (10) @(negedge clk);
    go(16'h03E8, 8'h64, 1'b0, 8'h0A, 8'h00, 1'b0, 8);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
